d_cache: RTL and testbench
==========================

D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, meaning number of direct-mapped blocks (power of two, 2..64).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have proc_read  input  1  core load request.
REQ-005 SHALL have proc_write  input  1  core store request.
REQ-006 SHALL have proc_addr  input  30  core word address: tag | index | word offset[1:0].
REQ-007 SHALL have proc_wdata  input  32  store data, stored as presented with no byte swap.
REQ-008 SHALL have proc_stall  output  1  high while the request cannot complete this cycle.
REQ-009 SHALL have proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0.
REQ-010 SHALL have mem_read  output  1  block fetch request.
REQ-011 SHALL have mem_write  output  1  block write-back request.
REQ-012 SHALL have mem_addr  output  28  block address, i.e. proc_addr[29:2].
REQ-013 SHALL have mem_wdata  output  128  write-back block; word w on bits [32w+31:32w].
REQ-014 SHALL have mem_rdata  input  128  fetched block, same word layout.
REQ-015 SHALL have mem_ready  input  1  one-cycle pulse; completes the pending mem_read or mem_write.

Function
REQ-016 SHALL be direct-mapped, write-back, write-allocate, with 4 words per block; IDX_W=log2(NUM_SETS); TAG_W=28-IDX_W.
REQ-017 SHALL hold per set: valid, dirty, tag[TAG_W], data[128].
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-019 In IDLE with a request and (valid && tag match), SHALL complete in the same cycle with proc_stall=0: read returns the word combinationally; write updates the word and sets dirty at the next edge.
REQ-020 In IDLE with a request and a miss, SHALL drive proc_stall=1 combinationally, then go to WRITEBACK if valid&&dirty, else to ALLOCATE.
REQ-021 In WRITEBACK, SHALL assert mem_write=1 with mem_addr={old tag,index} and mem_wdata=old block, all held stable until mem_ready; on mem_ready SHALL go to ALLOCATE.
REQ-022 In ALLOCATE, SHALL assert mem_read=1 with mem_addr=proc_addr[29:2] until mem_ready; on mem_ready SHALL write the block, set valid=1, dirty=0, tag=new, and return to IDLE, where the retried request hits.
REQ-023 SHALL drive mem_read/mem_write/mem_addr/mem_wdata from registers; mem_read and mem_write SHALL never be high together.
REQ-024 SHALL keep proc_stall=1 in WRITEBACK and ALLOCATE.
REQ-025 Clean-miss latency: stall from the request cycle through the cycle after mem_ready, with zero extra cycles beyond the ALLOCATE handshake.
REQ-026 proc_read and proc_write both high SHALL be treated as a write.
REQ-027 With no request, SHALL drive proc_stall=0 and proc_rdata=0, and cache state SHALL not change.
REQ-028 SHALL ignore mem_ready in IDLE.
REQ-029 The core SHALL hold the request stable while stalled; the cache need not latch it.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear all valid and dirty bits, and set proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-031 rst during WRITEBACK or ALLOCATE SHALL abandon the transfer, with no writeback retried and no partial fill.

Configuration
REQ-032 With D_CACHE_STATS_EN defined, SHALL add outputs hit_cnt (32) and miss_cnt (32):
- hit_cnt increments per IDLE hit;
- miss_cnt increments per IDLE miss detection;
- both saturate at 32'hFFFFFFFF;
- both clear on rst.
REQ-033 Without D_CACHE_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-034 Package d_cache_pkg SHALL hold the state enum, BLOCK_W=128, WORDS=4, and the TAG_W/IDX_W derivation functions.
REQ-035 SHALL instantiate one sub-module, d_cache_array, holding valid/dirty/tag/data, with a combinational read port and one synchronous write port.

Verification
REQ-036 Read miss to empty cache, addr 30'h0000_0010, mem_ready after 3 cycles with block {D,C,B,A}:
- mem_read=1 and mem_addr=28'h4 until mem_ready;
- then the read returns A with proc_stall=0.
REQ-037 Write hit: after REQ-036, write 32'hDEADBEEF to addr 30'h11 -> no stall; a subsequent read of 30'h11 returns 32'hDEADBEEF.
REQ-038 Dirty eviction: read of a conflicting addr 30'h0000_0090 (same index, NUM_SETS=8):
- mem_write=1, mem_addr=28'h4, mem_wdata word1=32'hDEADBEEF;
- then mem_read with mem_addr=28'h24;
- mem_read and mem_write never overlap.
REQ-039 Reset mid-ALLOCATE: rst pulse before mem_ready -> mem_read=0 immediately; a later read of the same addr misses again.
REQ-040 Simultaneous proc_read=proc_write=1 on a hit -> treated as a write, dirty set, proc_stall=0.
REQ-041 With D_CACHE_STATS_EN, the sequence of REQ-036..038 -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared constants, FSM state encoding and block/word helpers for the
// direct-mapped write-back data cache.
package d_cache_pkg;

  localparam int BLOCK_W    = 128;
  localparam int WORDS      = 4;
  localparam int BLK_ADDR_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int num_sets);
    return BLK_ADDR_W - $clog2(num_sets);
  endfunction

  function automatic logic [31:0] get_word(input logic [BLOCK_W-1:0] blk,
                                           input logic [1:0]         off);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (off == 2'(i)) w = blk[32*i +: 32];
    end
    return w;
  endfunction

  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [1:0]         off,
                                                  input logic [31:0]        w);
    logic [BLOCK_W-1:0] b;
    b = blk;
    for (int i = 0; i < WORDS; i++) begin
      if (off == 2'(i)) b[32*i +: 32] = w;
    end
    return b;
  endfunction

endpackage

// File: rtl/d_cache_array.sv
// Per-set storage: valid/dirty flags (async cleared) plus tag and block data,
// one combinational read port and one synchronous write port.
module d_cache_array
  import d_cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [BLOCK_W-1:0] rd_data_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic               wr_valid_i,
  input  logic               wr_dirty_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [BLOCK_W-1:0] wr_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data need no reset: they are only meaningful behind valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
// Optional hit/miss counters are built when D_CACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or ALLOCATE
// WRITEBACK | victim block held on mem_write until mem_ready
// ALLOCATE  | mem_read of the requested block until mem_ready, then fill
module d_cache
  import d_cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [29:0]           proc_addr,
  input  logic [31:0]           proc_wdata,
  output logic                  proc_stall,
  output logic [31:0]           proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [27:0]           mem_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ready
`ifdef D_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(NUM_SETS);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] WRITEBACK = ST_WRITEBACK;
  localparam logic [1:0] ALLOCATE  = ST_ALLOCATE;

  logic [1:0]         state_q, state_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [27:0]        mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         req_off;
  logic               req_any;
  logic               hit;

  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [BLOCK_W-1:0] rd_data;

  logic               wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]   wr_tag;
  logic [BLOCK_W-1:0] wr_data;
  logic               stall_c;
  logic [31:0]        rdata_c;

  assign req_off = proc_addr[1:0];
  assign req_idx = proc_addr[IDX_W+1:2];
  assign req_tag = proc_addr[29:IDX_W+2];
  assign req_any = proc_read | proc_write;
  assign hit     = rd_valid && (rd_tag == req_tag);

  d_cache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (req_idx),
    .wr_valid_i (wr_valid),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    wr_valid    = rd_valid;
    wr_dirty    = rd_dirty;
    wr_tag      = rd_tag;
    wr_data     = rd_data;
    stall_c     = 1'b0;
    rdata_c     = '0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          if (hit) begin
            // Write wins when both strobes are high.
            if (proc_write) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
              wr_data  = put_word(rd_data, req_off, proc_wdata);
            end else begin
              rdata_c = get_word(rd_data, req_off);
            end
          end else begin
            stall_c = 1'b1;
            if (rd_valid && rd_dirty) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {rd_tag, req_idx};
              mem_wdata_d = rd_data;
            end else begin
              state_d    = ALLOCATE;
              mem_read_d = 1'b1;
              mem_addr_d = proc_addr[29:2];
            end
          end
        end
      end
      WRITEBACK: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = proc_addr[29:2];
        end
      end
      ALLOCATE: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          wr_en      = 1'b1;
          wr_valid   = 1'b1;
          wr_dirty   = 1'b0;
          wr_tag     = req_tag;
          wr_data    = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Reset overrides the combinational miss stall so the core sees no stall.
  assign proc_stall = stall_c & ~rst;
  assign proc_rdata = rdata_c;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == IDLE) && req_any && hit;
  assign miss_evt = (state_q == IDLE) && req_any && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_d_cache.sv
// Directed self-checking bench for d_cache (NUM_SETS=8): miss fill, write hit,
// dirty eviction, reset mid-transfer, read+write collision and idle behaviour.
module tb_d_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003, WD = 32'hD0D0_0004;
  localparam logic [31:0] WE = 32'hE0E0_0005, WF = 32'hF0F0_0006;
  localparam logic [31:0] WG = 32'h1111_0007, WH = 32'h2222_0008;

  always #5 clk = ~clk;

  d_cache #(.NUM_SETS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // mem_read and mem_write must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (mem_read && mem_write) begin
        n_fail++;
        $display("FAIL overlap: mem_read=%b mem_write=%b at %0t", mem_read, mem_write, $time);
      end
    end
  end

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    #3;
    n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", proc_stall); end
    n_checks++; if (mem_read !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
    n_checks++; if (mem_write !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    n_checks++; if (mem_addr !== 28'h0)  begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 128'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_read_miss();
    tick();
    proc_read = 1; proc_addr = 30'h10; #1;
    n_checks++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL miss_stall_req: got %b want 1", proc_stall); end
    n_checks++; if (mem_read !== 1'b0)   begin n_fail++; $display("FAIL miss_mem_read_early: got %b want 0", mem_read); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++; if (mem_read !== 1'b1)  begin n_fail++; $display("FAIL alloc_mem_read[%0d]: got %b want 1", i, mem_read); end
      n_checks++; if (mem_addr !== 28'h4) begin n_fail++; $display("FAIL alloc_mem_addr[%0d]: got %h want 4", i, mem_addr); end
      n_checks++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL alloc_stall[%0d]: got %b want 1", i, proc_stall); end
      if (i == 2) begin mem_ready = 1; mem_rdata = {WD, WC, WB, WA}; end
    end
    tick(); mem_ready = 0; #1;
    n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall: got %b want 0", proc_stall); end
    n_checks++; if (proc_rdata !== WA)   begin n_fail++; $display("FAIL fill_rdata: got %h want %h", proc_rdata, WA); end
    n_checks++; if (mem_read !== 1'b0)   begin n_fail++; $display("FAIL fill_mem_read_drop: got %b want 0", mem_read); end
    tick(); proc_addr = 30'h12; #1;
    n_checks++; if (proc_rdata !== WC)   begin n_fail++; $display("FAIL hit_word2: got %h want %h", proc_rdata, WC); end
  endtask

  task automatic test_write_hit();
    tick(); proc_read = 0; proc_write = 1; proc_addr = 30'h11; proc_wdata = 32'hDEADBEEF; #1;
    n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL wr_hit_stall: got %b want 0", proc_stall); end
    tick(); proc_write = 0; proc_read = 1; #1;
    n_checks++; if (proc_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_hit_readback: got %h want deadbeef", proc_rdata); end
    proc_addr = 30'h10; #1;
    n_checks++; if (proc_rdata !== WA) begin n_fail++; $display("FAIL wr_hit_neighbour: got %h want %h", proc_rdata, WA); end
  endtask

  task automatic test_dirty_evict();
    tick(); proc_read = 1; proc_addr = 30'h90; #1;
    n_checks++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL evict_stall_req: got %b want 1", proc_stall); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL wb_mem_write[%0d]: got %b want 1", i, mem_write); end
      n_checks++; if (mem_addr !== 28'h4) begin n_fail++; $display("FAIL wb_mem_addr[%0d]: got %h want 4", i, mem_addr); end
      n_checks++; if (mem_wdata !== {WD, WC, 32'hDEADBEEF, WA})
        begin n_fail++; $display("FAIL wb_mem_wdata[%0d]: got %h", i, mem_wdata); end
      if (i == 1) mem_ready = 1;
    end
    tick(); mem_ready = 0; #1;
    n_checks++; if (mem_write !== 1'b0)  begin n_fail++; $display("FAIL evict_wr_drop: got %b want 0", mem_write); end
    n_checks++; if (mem_read !== 1'b1)   begin n_fail++; $display("FAIL evict_rd: got %b want 1", mem_read); end
    n_checks++; if (mem_addr !== 28'h24) begin n_fail++; $display("FAIL evict_rd_addr: got %h want 24", mem_addr); end
    n_checks++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL evict_alloc_stall: got %b want 1", proc_stall); end
    mem_ready = 1; mem_rdata = {WH, WG, WF, WE};
    tick(); mem_ready = 0; #1;
    n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL evict_fill_stall: got %b want 0", proc_stall); end
    n_checks++; if (proc_rdata !== WE)   begin n_fail++; $display("FAIL evict_fill_rdata: got %h want %h", proc_rdata, WE); end
    // Freshly filled block is clean: evicting it must skip write-back.
    tick(); proc_addr = 30'h10; #1;
    tick(); #1;
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL clean_evict_no_wb: got %b want 0", mem_write); end
    n_checks++; if (mem_read !== 1'b1)  begin n_fail++; $display("FAIL clean_evict_rd: got %b want 1", mem_read); end
    mem_ready = 1; mem_rdata = {WD, WC, 32'hDEADBEEF, WA};
    tick(); mem_ready = 0; proc_addr = 30'h11; #1;
    n_checks++; if (proc_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL refill_rdata: got %h want deadbeef", proc_rdata); end
  endtask

  task automatic test_rw_both();
    tick(); proc_read = 1; proc_write = 1; proc_addr = 30'h13; proc_wdata = 32'h1234_5678; #1;
    n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL rw_both_stall: got %b want 0", proc_stall); end
    tick(); proc_write = 0; #1;
    n_checks++; if (proc_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_both_readback: got %h want 12345678", proc_rdata); end
    tick(); proc_addr = 30'h90; #1;
    tick(); #1;
    n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rw_both_dirty: got %b want 1", mem_write); end
    n_checks++; if (mem_wdata[127:96] !== 32'h1234_5678)
      begin n_fail++; $display("FAIL rw_both_wb_word3: got %h want 12345678", mem_wdata[127:96]); end
  endtask

  task automatic test_reset_mid_alloc();
    mem_ready = 1;
    tick(); mem_ready = 0; #1;
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL pre_rst_alloc: got %b want 1", mem_read); end
    proc_read = 0; rst = 1; #1;
    n_checks++; if (mem_read !== 1'b0)   begin n_fail++; $display("FAIL rst_async_mem_read: got %b want 0", mem_read); end
    n_checks++; if (proc_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall: got %b want 0", proc_stall); end
    tick(); rst = 0;
    tick(); proc_read = 1; proc_addr = 30'h90; #1;
    n_checks++; if (proc_stall !== 1'b1) begin n_fail++; $display("FAIL post_rst_miss: got %b want 1", proc_stall); end
    tick(); #1;
    n_checks++; if (mem_write !== 1'b0)  begin n_fail++; $display("FAIL post_rst_no_wb: got %b want 0", mem_write); end
    n_checks++; if (mem_read !== 1'b1)   begin n_fail++; $display("FAIL post_rst_rd: got %b want 1", mem_read); end
    n_checks++; if (mem_addr !== 28'h24) begin n_fail++; $display("FAIL post_rst_addr: got %h want 24", mem_addr); end
    mem_ready = 1; mem_rdata = {WH, WG, WF, WE};
    tick(); mem_ready = 0; proc_addr = 30'h93; #1;
    n_checks++; if (proc_rdata !== WH) begin n_fail++; $display("FAIL post_rst_fill: got %h want %h", proc_rdata, WH); end
  endtask

  task automatic test_idle();
    tick(); proc_read = 0; proc_write = 0; mem_ready = 1; #1;
    n_checks++; if (proc_stall !== 1'b0)  begin n_fail++; $display("FAIL idle_stall: got %b want 0", proc_stall); end
    n_checks++; if (proc_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata: got %h want 0", proc_rdata); end
    tick(); mem_ready = 0; #1;
    n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0)
      begin n_fail++; $display("FAIL idle_ready_ignored: rd=%b wr=%b want 0 0", mem_read, mem_write); end
    proc_read = 1; proc_addr = 30'h92; #1;
    n_checks++; if (proc_rdata !== WG || proc_stall !== 1'b0)
      begin n_fail++; $display("FAIL idle_state_kept: rdata=%h stall=%b want %h 0", proc_rdata, proc_stall, WG); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_dirty_evict();
    test_rw_both();
    test_reset_mid_alloc();
    test_idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
